// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_fun,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_fun,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic gnt, win, acc, rsp_hs;
  logic [WIDTH-1:0] op_a, op_b;
  logic [3:0] op_fun;
  assign acc = state == IDLE && (req0_valid || req1_valid);
  assign rsp_hs = state == RESP && (gnt ? rsp1_ready : rsp0_ready);
`ifdef ALU_ARB_RR_EN
  logic last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (rsp_hs) last <= gnt;
  assign win = (req0_valid && req1_valid) ? ~last : req1_valid;
`else
  assign win = req1_valid && !req0_valid;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (acc ? EXEC : IDLE) :
               state == EXEC ? RESP : (rsp_hs ? IDLE : RESP);
  always_comb begin
    req0_ready = acc && !win;
    req1_ready = acc && win;
    rsp0_valid = state == RESP && !gnt;
    rsp1_valid = state == RESP && gnt;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      op_fun <= '0;
      rsp_data <= '0;
      op_cnt <= '0;
    end else begin
      if (acc) begin
        gnt <= win;
        op_a <= win ? req1_a : req0_a;
        op_b <= win ? req1_b : req0_b;
        op_fun <= win ? req1_fun : req0_fun;
      end
      if (state == EXEC) rsp_data <= alu_out;
      if (rsp_hs) op_cnt <= op_cnt + CNT_W'(1);
    end
  // ALU inputs come straight from the op registers so they never glitch.
  assign alu_a = op_a;
  assign alu_b = op_b;
  assign alu_fun = op_fun;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one combinational 32-bit ALU between two requesters, e.g. the OTTER datapath execute path and a memory-mapped math-game coprocessor port.
- Accepts one operation at a time over a valid/ready request channel and arbitrates when both requesters are valid.
- Drives the ALU from registered operands and captures ALU_OUT into a result register.
- Returns the result on the granted requester's valid/ready response channel.

## Interface
- WIDTH, 32, operand and result width; ALU_FUN is always 4 bits
- CNT_W, 16, width of the completed-operation counter
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ0_VALID / REQ1_VALID  in  1  operation request
- REQ0_READY / REQ1_READY  out  1  request accepted this cycle when high with VALID
- REQ0_A, REQ0_B / REQ1_A, REQ1_B  in  WIDTH  operands
- REQ0_FUN / REQ1_FUN  in  4  ALU function code, passed through unmodified
- RSP0_VALID / RSP1_VALID  out  1  result available
- RSP0_READY / RSP1_READY  in  1  requester takes result
- RSP_DATA  out  WIDTH  result register, shared by both response channels
- ALU_A, ALU_B  out  WIDTH  to ALU operands
- ALU_FUN  out  4  to ALU function select
- ALU_OUT  in  WIDTH  from ALU result
- BUSY  out  1  high in any state other than IDLE
- OP_CNT  out  CNT_W  count of completed (response-handshaked) operations

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner is selected combinationally from REQ0_VALID/REQ1_VALID.
  - Only the winner's REQx_READY is high. READY is low in EXEC and RESP.
  - On REQx_VALID & REQx_READY:
    - Latch A, B and FUN into op registers.
    - Latch grant index into GNT.
    - Go to EXEC.
- EXEC:
  - ALU_A/ALU_B/ALU_FUN are driven from the op registers.
  - At the clock edge, ALU_OUT is captured into RSP_DATA. Go to RESP.
- RESP:
  - RSP[GNT]_VALID is high. The other RSP_VALID is low.
  - RSP_DATA is held stable until RSP[GNT]_READY is high.
  - On that handshake: OP_CNT increments (wraps at 2^CNT_W-1 to 0), LAST is set to GNT, and the FSM returns to IDLE.
- ALU_A/ALU_B/ALU_FUN always reflect the op registers, including outside EXEC. This prevents ALU-input glitches.
- Arbitration with both requesters valid in IDLE:
  - Under ALU_ARB_RR_EN: the requester not equal to LAST wins.
  - Otherwise: requester 0 wins.
- Single valid requester: it wins regardless of LAST.
- A requester may drop VALID before acceptance. READY follows combinationally, and no operation is lost or started.
- RSP_READY asserted while RSP_VALID is low is ignored.

## Timing
- Reset values:
  - State = IDLE; GNT = 0; LAST = 1, so requester 0 wins the first tie.
  - Op registers = 0; RSP_DATA = 0; OP_CNT = 0.
  - All READY/RSP_VALID outputs = 0; BUSY = 0.
- Latency: request accepted at edge N; EXEC during cycle N+1; RSP_VALID high in cycle N+2.
- Minimum 3 cycles per operation. With RSP_READY tied high, throughput is 1 operation per 3 cycles.
- No new request is accepted in the cycle the response handshakes. The IDLE cycle is mandatory.
- REQx_READY depends combinationally on both REQx_VALID inputs. There is no path from RSP_READY to REQ_READY.
- Reset asserted mid-operation:
  - The FSM returns to IDLE immediately (asynchronous).
  - The pending result is discarded and no RSP_VALID is produced. OP_CNT is cleared.
- Reset deassertion is synchronized externally. The block samples inputs from the first rising edge after RST_N goes high.

## Configuration
- ALU_ARB_RR_EN defined:
  - Round-robin arbitration on ties, using LAST.
  - Alternates strictly 0,1,0,1 under continuous dual requests.
- ALU_ARB_RR_EN undefined:
  - Fixed priority, requester 0 always wins ties. Requester 1 may starve.
  - The LAST register is not implemented.

## Test plan
- Single op: REQ0 A=5, B=3, FUN=4'b0000, RSP0_READY=1 -> RSP0_VALID in cycle N+2, RSP_DATA=8, OP_CNT=1, RSP1_VALID never high.
- Back-pressure: REQ1 A=10, B=4, FUN=4'b1000, RSP1_READY low 5 cycles -> RSP_DATA=6 held stable 6 cycles, both READY low, BUSY=1 throughout.
- Tie arbitration:
  - Both valid continuously for 4 ops, with REQ0 FUN=0000 (A=1, B=1) and REQ1 FUN=0110 (A=0xF0, B=0x0F).
  - RR_EN: grants 0,1,0,1, results 2,0xFF,2,0xFF.
  - No RR_EN: grants 0,0,0,0.
- Withdrawn request: REQ1_VALID pulses while FSM in EXEC, then drops -> REQ1_READY never high, OP_CNT unchanged by it.
- Reset mid-op: RST_N low during EXEC of A=7, B=2, FUN=0000 -> next cycle BUSY=0, RSP_DATA=0, no RSP_VALID after release.
- Counter wrap: CNT_W=2, 5 completed ops -> OP_CNT sequence 1,2,3,0,1.
